// File: rtl/int_timer_ctrl_if.sv
// Decode/fetch-side bundle between the pipeline and the interrupt timer controller.
interface int_timer_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             cnt_int;
    logic             cnt_int_sel;
    logic             cnt_int_disable;
    logic [CNT_W-1:0] cnt_period;
    logic             rti;
    logic             stallD;
    logic [31:0]      pcF;
    logic             int_en1;
    logic [31:0]      int_vector;
    logic [31:0]      epc;
    logic             int_pending;
    logic             in_isr;
    logic [7:0]       overrun_cnt;

    modport master (
        output cnt_int, cnt_int_sel, cnt_int_disable, cnt_period, rti, stallD, pcF,
        input  int_en1, int_vector, epc, int_pending, in_isr, overrun_cnt
    );

    modport slave (
        input  cnt_int, cnt_int_sel, cnt_int_disable, cnt_period, rti, stallD, pcF,
        output int_en1, int_vector, epc, int_pending, in_isr, overrun_cnt
    );
endinterface

// File: rtl/int_timer_ctrl.sv
// Countdown timer interrupt controller: one-shot/periodic timer plus non-nesting service FSM.
// Optional lost-expiry counter enabled by defining INT_OVERRUN_CNT_EN.
module int_timer_ctrl #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0180,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    int_timer_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        TMR_OFF      = 2'd0,
        TMR_ONESHOT  = 2'd1,
        TMR_PERIODIC = 2'd2
    } tmr_state_e;

    typedef enum logic {
        SVC_RUN = 1'b0,
        SVC_ISR = 1'b1
    } svc_state_e;

    tmr_state_e       tmr_q, tmr_d;
    svc_state_e       svc_q, svc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [31:0]      epc_q, epc_d;
    logic             pend_q, pend_d;

    logic dec_valid;
    logic expiry;
    logic load;
    logic kill;
    logic accept;

    assign dec_valid = ~bus.stallD;
    assign expiry    = (tmr_q != TMR_OFF) && (cnt_q == CNT_W'(1));
    assign load      = dec_valid && bus.cnt_int && !bus.cnt_int_disable && (bus.cnt_period != '0);
    assign kill      = dec_valid && bus.cnt_int && !load;
    assign accept    = (svc_q == SVC_RUN) && pend_q && dec_valid;

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q    <= TMR_OFF;
            svc_q    <= SVC_RUN;
            cnt_q    <= '0;
            period_q <= '0;
            epc_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            svc_q    <= svc_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            epc_q    <= epc_d;
            pend_q   <= pend_d;
        end
    end

    // Timer and service next-state; a new load overrides the expiry reload, disable overrides all
    always_comb begin
        tmr_d    = tmr_q;
        svc_d    = svc_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        epc_d    = epc_q;
        pend_d   = pend_q;

        case (tmr_q)
            TMR_ONESHOT: begin
                if (expiry) begin
                    tmr_d = TMR_OFF;
                    cnt_d = '0;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            TMR_PERIODIC: begin
                if (expiry) begin
                    cnt_d = period_q;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: tmr_d = TMR_OFF;
        endcase

        if (load) begin
            tmr_d    = bus.cnt_int_sel ? TMR_PERIODIC : TMR_ONESHOT;
            cnt_d    = bus.cnt_period;
            period_d = bus.cnt_period;
        end else if (kill) begin
            tmr_d = TMR_OFF;
            cnt_d = '0;
        end

        if (accept) pend_d = 1'b0;
        if (expiry) pend_d = 1'b1;
        if (kill)   pend_d = 1'b0;

        case (svc_q)
            SVC_RUN: begin
                if (accept) begin
                    svc_d = SVC_ISR;
                    epc_d = bus.pcF;
                end
            end
            SVC_ISR: begin
                if (dec_valid && bus.rti) svc_d = SVC_RUN;
            end
            default: svc_d = SVC_RUN;
        endcase
    end

    assign bus.int_en1     = accept;
    assign bus.int_vector  = INT_VECTOR;
    assign bus.epc         = epc_q;
    assign bus.int_pending = pend_q;
    assign bus.in_isr      = (svc_q == SVC_ISR);

`ifdef INT_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;

    // Counts expiries that land on an already-pending, unserviced request
    always_comb begin
        ovr_d = ovr_q;
        if (expiry && pend_q && !accept && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
        if (dec_valid && bus.cnt_int && bus.cnt_int_disable) ovr_d = 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovr_q <= 8'h00;
        else        ovr_q <= ovr_d;
    end

    assign bus.overrun_cnt = ovr_q;
`else
    assign bus.overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_int_timer_ctrl.sv
// Self-checking bench for int_timer_ctrl: directed scenarios plus randomized run against a timestamp-based model.
module tb_int_timer_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam logic [31:0] VEC   = 32'h0000_0180;
`ifdef INT_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    int_timer_ctrl_if #(.CNT_W(CNT_W)) bus ();

    int_timer_ctrl #(.INT_VECTOR(VEC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: expiries tracked as absolute edge numbers
    int          m_mode;    // 0 off, 1 one-shot, 2 periodic
    longint      m_period;
    longint      m_next;
    longint      cyc;
    bit          m_pend;
    bit          m_isr;
    logic [31:0] m_epc;
    int          m_ovr;

    function automatic bit m_en1();
        return !m_isr && m_pend && !bus.stallD;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_period = 0; m_next = 0; cyc = 0;
        m_pend = 1'b0; m_isr = 1'b0; m_epc = 32'h0; m_ovr = 0;
    endtask

    task automatic model_edge();
        longint c;
        bit valid, ex, acc, ld, kl, dis;
        c     = cyc + 1;
        valid = !bus.stallD;
        ex    = (m_mode != 0) && (m_next == c);
        acc   = !m_isr && m_pend && valid;
        ld    = valid && bus.cnt_int && !bus.cnt_int_disable && (bus.cnt_period != '0);
        kl    = valid && bus.cnt_int && !ld;
        dis   = valid && bus.cnt_int && bus.cnt_int_disable;
        if (ex && m_pend && !acc && m_ovr < 255) m_ovr++;
        if (dis) m_ovr = 0;
        if (ex) begin
            if (m_mode == 1) m_mode = 0;
            else             m_next = c + m_period;
        end
        if (ld) begin
            m_mode   = bus.cnt_int_sel ? 2 : 1;
            m_period = longint'(bus.cnt_period);
            m_next   = c + m_period;
        end
        if (kl) m_mode = 0;
        if (acc) begin
            m_pend = 1'b0; m_isr = 1'b1; m_epc = bus.pcF;
        end else if (m_isr && valid && bus.rti) begin
            m_isr = 1'b0;
        end
        if (ex) m_pend = 1'b1;
        if (kl) m_pend = 1'b0;
        cyc = c;
    endtask

    task automatic drive_idle();
        bus.cnt_int = 1'b0; bus.cnt_int_sel = 1'b0; bus.cnt_int_disable = 1'b0;
        bus.cnt_period = '0; bus.rti = 1'b0; bus.stallD = 1'b0; bus.pcF = 32'h0;
    endtask

    // One rising edge; returns at the following falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic load(input bit sel, input int unsigned p);
        bus.cnt_int = 1'b1; bus.cnt_int_sel = sel; bus.cnt_period = CNT_W'(p);
        tick();
        bus.cnt_int = 1'b0; bus.cnt_int_sel = 1'b0; bus.cnt_period = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", bus.int_pending); end
        n_checks++; if (bus.in_isr !== 1'b0) begin n_fail++; $display("FAIL reset_in_isr got=%b exp=0", bus.in_isr); end
        n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", bus.epc); end
        n_checks++; if (bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_int_en1 got=%b exp=0", bus.int_en1); end
        n_checks++; if (bus.overrun_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_overrun got=%h exp=00", bus.overrun_cnt); end
        n_checks++; if (bus.int_vector !== VEC) begin n_fail++; $display("FAIL int_vector got=%h exp=%h", bus.int_vector, VEC); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_oneshot();
        do_reset();
        load(1'b0, 5);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL oneshot_early edge=%0d got=%b exp=0", k, bus.int_pending); end
        end
        tick();
        n_checks++; if (bus.int_pending !== 1'b1) begin n_fail++; $display("FAIL oneshot_expiry got=%b exp=1", bus.int_pending); end
        bus.pcF = 32'h0000_1234;
        #1;
        n_checks++; if (bus.int_en1 !== 1'b1) begin n_fail++; $display("FAIL oneshot_en1 got=%b exp=1", bus.int_en1); end
        tick();
        n_checks++; if (bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL oneshot_en1_pulse got=%b exp=0", bus.int_en1); end
        n_checks++; if (bus.epc !== 32'h0000_1234) begin n_fail++; $display("FAIL oneshot_epc got=%h exp=00001234", bus.epc); end
        n_checks++; if (bus.in_isr !== 1'b1) begin n_fail++; $display("FAIL oneshot_in_isr got=%b exp=1", bus.in_isr); end
        n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL oneshot_pend_clr got=%b exp=0", bus.int_pending); end
        bus.pcF = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL oneshot_off cyc=%0d got=%b exp=0", k, bus.int_pending); end
        end
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
        n_checks++; if (bus.in_isr !== 1'b0) begin n_fail++; $display("FAIL oneshot_rti got=%b exp=0", bus.in_isr); end
        n_checks++; if (bus.epc !== 32'h0000_1234) begin n_fail++; $display("FAIL oneshot_epc_hold got=%h exp=00001234", bus.epc); end
        tick();
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
        n_checks++; if (bus.in_isr !== 1'b0 || bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL rti_in_run isr=%b en1=%b exp=0/0", bus.in_isr, bus.int_en1); end
    endtask

    task automatic test_periodic();
        int en_cnt;
        logic [7:0] exp_ovr;
        do_reset();
        load(1'b1, 3);
        en_cnt = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (bus.int_en1 === 1'b1) en_cnt++;
            if (e == 3) begin
                n_checks++; if (bus.int_pending !== 1'b1) begin n_fail++; $display("FAIL periodic_first got=%b exp=1", bus.int_pending); end
            end
        end
        exp_ovr = OVR_EN ? 8'd3 : 8'd0;
        n_checks++; if (en_cnt != 1) begin n_fail++; $display("FAIL periodic_en1_count got=%0d exp=1", en_cnt); end
        n_checks++; if (bus.overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL periodic_overrun got=%0d exp=%0d", bus.overrun_cnt, exp_ovr); end
        n_checks++; if (bus.in_isr !== 1'b1) begin n_fail++; $display("FAIL periodic_in_isr got=%b exp=1", bus.in_isr); end
        bus.cnt_int = 1'b1; bus.cnt_int_disable = 1'b1;
        tick();
        bus.cnt_int = 1'b0; bus.cnt_int_disable = 1'b0;
        n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL periodic_disable_pend got=%b exp=0", bus.int_pending); end
        n_checks++; if (bus.overrun_cnt !== 8'h00) begin n_fail++; $display("FAIL periodic_disable_ovr got=%0d exp=0", bus.overrun_cnt); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL periodic_stopped cyc=%0d got=%b exp=0", k, bus.int_pending); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        load(1'b0, 2);
        tick();
        tick();
        n_checks++; if (bus.int_pending !== 1'b1) begin n_fail++; $display("FAIL stall_pend got=%b exp=1", bus.int_pending); end
        bus.stallD = 1'b1; bus.pcF = 32'hAAAA_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL stall_en1 cyc=%0d got=%b exp=0", k, bus.int_en1); end
            tick();
            n_checks++; if (bus.in_isr !== 1'b0 || bus.int_pending !== 1'b1) begin n_fail++; $display("FAIL stall_hold cyc=%0d isr=%b pend=%b exp=0/1", k, bus.in_isr, bus.int_pending); end
        end
        bus.stallD = 1'b0; bus.pcF = 32'h0000_BEEC;
        #1;
        n_checks++; if (bus.int_en1 !== 1'b1) begin n_fail++; $display("FAIL stall_release_en1 got=%b exp=1", bus.int_en1); end
        tick();
        n_checks++; if (bus.epc !== 32'h0000_BEEC) begin n_fail++; $display("FAIL stall_epc got=%h exp=0000beec", bus.epc); end
        n_checks++; if (bus.in_isr !== 1'b1) begin n_fail++; $display("FAIL stall_in_isr got=%b exp=1", bus.in_isr); end
    endtask

    task automatic test_rti_expiry();
        do_reset();
        load(1'b1, 4);
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (bus.int_en1 !== 1'b1) begin n_fail++; $display("FAIL rtiexp_first_en1 got=%b exp=1", bus.int_en1); end
        tick();
        n_checks++; if (bus.in_isr !== 1'b1) begin n_fail++; $display("FAIL rtiexp_isr got=%b exp=1", bus.in_isr); end
        tick();
        tick();
        bus.rti = 1'b1;
        #1;
        n_checks++; if (bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL rtiexp_same_cycle_en1 got=%b exp=0", bus.int_en1); end
        tick();
        bus.rti = 1'b0;
        n_checks++; if (bus.in_isr !== 1'b0 || bus.int_pending !== 1'b1) begin n_fail++; $display("FAIL rtiexp_return isr=%b pend=%b exp=0/1", bus.in_isr, bus.int_pending); end
        bus.pcF = 32'h0000_2000;
        #1;
        n_checks++; if (bus.int_en1 !== 1'b1) begin n_fail++; $display("FAIL rtiexp_next_en1 got=%b exp=1", bus.int_en1); end
        tick();
        n_checks++; if (bus.epc !== 32'h0000_2000 || bus.in_isr !== 1'b1) begin n_fail++; $display("FAIL rtiexp_reenter epc=%h isr=%b exp=00002000/1", bus.epc, bus.in_isr); end
    endtask

    task automatic test_disable_expiry();
        int en_cnt;
        do_reset();
        load(1'b0, 3);
        tick();
        tick();
        bus.cnt_int = 1'b1; bus.cnt_int_disable = 1'b1;
        tick();
        bus.cnt_int = 1'b0; bus.cnt_int_disable = 1'b0;
        n_checks++; if (bus.int_pending !== 1'b0) begin n_fail++; $display("FAIL disexp_pend got=%b exp=0", bus.int_pending); end
        en_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.int_en1 === 1'b1 || bus.int_pending === 1'b1) en_cnt++;
            tick();
        end
        n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL disexp_after got=%0d cycles active exp=0", en_cnt); end
    endtask

    task automatic test_reset_mid();
        int act_cnt;
        do_reset();
        load(1'b0, 2);
        tick();
        bus.pcF = 32'h0000_3000;
        tick();
        load(1'b1, 10);
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (bus.in_isr !== 1'b1 || bus.epc !== 32'h0000_3000) begin n_fail++; $display("FAIL rstmid_pre isr=%b epc=%h exp=1/00003000", bus.in_isr, bus.epc); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.in_isr !== 1'b0) begin n_fail++; $display("FAIL rstmid_isr got=%b exp=0", bus.in_isr); end
        n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL rstmid_epc got=%h exp=0", bus.epc); end
        n_checks++; if (bus.int_pending !== 1'b0 || bus.int_en1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_pend pend=%b en1=%b exp=0/0", bus.int_pending, bus.int_en1); end
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        act_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.int_pending === 1'b1 || bus.int_en1 === 1'b1) act_cnt++;
        end
        n_checks++; if (act_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_resume got=%0d cycles active exp=0", act_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] exp_ovr;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.stallD          = ($urandom_range(0, 3) == 0);
            bus.cnt_int         = ($urandom_range(0, 11) == 0);
            bus.cnt_int_sel     = 1'($urandom_range(0, 1));
            bus.cnt_int_disable = ($urandom_range(0, 5) == 0);
            bus.cnt_period      = CNT_W'($urandom_range(0, 7));
            bus.rti             = ($urandom_range(0, 7) == 0);
            bus.pcF             = $urandom;
            #1;
            n_checks++; if (bus.int_en1 !== m_en1()) begin n_fail++; $display("FAIL rand_en1 i=%0d got=%b exp=%b", i, bus.int_en1, m_en1()); end
            tick();
            exp_ovr = OVR_EN ? 8'(m_ovr) : 8'h00;
            n_checks++; if (bus.int_pending !== m_pend) begin n_fail++; $display("FAIL rand_pend i=%0d got=%b exp=%b", i, bus.int_pending, m_pend); end
            n_checks++; if (bus.in_isr !== m_isr) begin n_fail++; $display("FAIL rand_isr i=%0d got=%b exp=%b", i, bus.in_isr, m_isr); end
            n_checks++; if (bus.epc !== m_epc) begin n_fail++; $display("FAIL rand_epc i=%0d got=%h exp=%h", i, bus.epc, m_epc); end
            n_checks++; if (bus.overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL rand_ovr i=%0d got=%0d exp=%0d", i, bus.overrun_cnt, exp_ovr); end
        end
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stall();
        test_rti_expiry();
        test_disable_expiry();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_timer_ctrl.md
INT_TIMER_CTRL -- requirements
Module: int_timer_ctrl

Interface
REQ-001 Parameter: INT_VECTOR, 32'h0000_0180, handler address driven on int_vector.
REQ-002 Parameter: CNT_W, 32, period/counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cnt_int  in  1  decode-stage counter-interrupt instruction (op 110001).
REQ-006 cnt_int_sel  in  1  mode with cnt_int: 0 one-shot, 1 periodic.
REQ-007 cnt_int_disable  in  1  with cnt_int: stop timer, drop pending.
REQ-008 cnt_period  in  CNT_W  period operand (rs value) captured on load.
REQ-009 rti  in  1  decode-stage return-from-interrupt (op 110000).
REQ-010 stallD  in  1  decode stall; decode-stage inputs are ignored while high.
REQ-011 pcF  in  32  fetch PC, saved as return address.
REQ-012 int_en1  out  1  one-cycle request to redirect fetch to int_vector.
REQ-013 int_vector  out  32  constant INT_VECTOR.
REQ-014 epc  out  32  saved return address for rti.
REQ-015 int_pending  out  1  expiry waiting for service.
REQ-016 in_isr  out  1  handler executing.
REQ-017 overrun_cnt  out  8  lost-expiry count (see Configuration).

Function
REQ-018 Timer FSM states: OFF, ONESHOT, PERIODIC; service FSM states: RUN, ISR.
REQ-019 Decode event valid only when stallD=0; valid cnt_int with disable=0 and cnt_period!=0 loads counter=cnt_period and enters ONESHOT (sel=0) or PERIODIC (sel=1).
REQ-020 Valid cnt_int with cnt_period=0 or disable=1 enters OFF and clears int_pending.
REQ-021 In ONESHOT/PERIODIC counter decrements by 1 every cycle, no wrap below 1.
REQ-022 Expiry: counter==1 at an edge; int_pending set on that edge, exactly cnt_period edges after the load edge.
REQ-023 On expiry ONESHOT goes OFF; PERIODIC reloads counter with the captured period (no cycle lost).
REQ-024 Simultaneous load and expiry: load takes effect and expiry still sets int_pending; disable and expiry together: disable wins, int_pending=0.
REQ-025 In RUN with int_pending=1 and stallD=0: int_en1=1 for exactly one cycle, epc<=pcF, int_pending<=0, move to ISR.
REQ-026 int_en1 is combinational from state and stallD, never high in ISR or while stallD=1.
REQ-027 In ISR further expiries set int_pending but raise no request (no nesting).
REQ-028 Valid rti in ISR returns to RUN; a pending request is issued no earlier than the following cycle.
REQ-029 rti in RUN is ignored by this block; epc unchanged.
REQ-030 epc holds until the next accepted request.

Reset
REQ-031 reset low asynchronously forces: timer OFF, service RUN, counter=0, period=0, epc=0, int_pending=0, in_isr=0, int_en1=0, overrun_cnt=0.
REQ-032 reset deasserted mid-count does not resume; timer restarts only on a new cnt_int.

Configuration
REQ-033 Macro INT_OVERRUN_CNT_EN defined: overrun_cnt increments (saturating at 8'hFF) on each expiry while int_pending already 1; cleared by valid disable or reset.
REQ-034 Macro INT_OVERRUN_CNT_EN undefined: counter logic absent, overrun_cnt tied to 8'h00.

Verification
REQ-035 Load period 5 one-shot, stallD=0 -> int_pending rises 5 edges after load; int_en1 pulses 1 cycle; epc=pcF of that cycle; timer OFF.
REQ-036 Periodic period 3, handler never returns -> expiries every 3 cycles, one int_en1 only; with INT_OVERRUN_CNT_EN overrun_cnt counts 1,2,3...; without it stays 0.
REQ-037 Pending with stallD=1 for 4 cycles -> int_en1 held low, fires the cycle stallD drops, epc captured then.
REQ-038 rti in ISR same cycle as new expiry -> in_isr clears, int_en1 asserted next cycle, not same cycle.
REQ-039 Disable coinciding with expiry -> int_pending stays 0, timer OFF, no int_en1.
REQ-040 reset pulsed low mid-count (period 10 after 4 cycles) -> all outputs reset immediately, no later interrupt without reload.
